sync_barcode_sched: RTL and testbench

SYNC_BARCODE_SCHED -- requirements
Module: sync_barcode_sched

---
 rtl/sync_barcode_sched_pkg.sv | 8 +
 rtl/sync_barcode_sched_frame_timer.sv | 17 +
 rtl/sync_barcode_sched.sv | 80 ++++++++
 tb/tb_sync_barcode_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sync_barcode_sched_pkg.sv
// sync_pkg: shared state encoding and default timing for the barcode scheduler.
package sync_pkg;
  typedef enum logic [1:0] {IDLE, START, GAP, BIT} state_t;
  localparam int FS               = 25000;
  localparam int NBITS_DEF        = 12;
  localparam int PULSE_FRAMES_DEF = 250;
  localparam int BIT_FRAMES_DEF   = 500;
endpackage

// File: rtl/sync_barcode_sched_frame_timer.sv
// frame_timer: counts frame ticks up to a loadable length and strobes done on the last one.
module frame_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] len,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = tick && !clr && cnt == len - W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || done) ? '0 : tick ? cnt + W'(1) : cnt;
endmodule

// File: rtl/sync_barcode_sched.sv
// sync_barcode_sched: serialises a seconds word as a frame-timed barcode on sync_out.
// Define SYNC_PARITY_EN to append an even-parity bit after the data bits.
module sync_barcode_sched
  import sync_pkg::*;
#(
  parameter int NBITS        = NBITS_DEF,
  parameter int PULSE_FRAMES = PULSE_FRAMES_DEF,
  parameter int BIT_FRAMES   = BIT_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             frame_tick,
  input  logic             sec_tvalid,
  input  logic [NBITS-1:0] sec_tdata,
  output logic             sec_tready,
  output logic             sync_out,
  output logic             busy,
  output logic [7:0]       drop_cnt
);
`ifdef SYNC_PARITY_EN
  localparam int NT = NBITS + 1;
`else
  localparam int NT = NBITS;
`endif
  localparam int MF = PULSE_FRAMES > BIT_FRAMES ? PULSE_FRAMES : BIT_FRAMES;
  localparam int W  = $clog2(MF + 1);
  localparam int BW = $clog2(NT + 1);
  state_t          state;
  logic [NT-1:0]   sh;
  logic [BW-1:0]   bit_idx;
  logic            done, load;
  logic [W-1:0]    len;
  logic [NT-1:0]   word;
  assign sec_tready = 1'b1;
  assign busy       = state != IDLE;
  assign load       = state == IDLE && en && sec_tvalid;
  assign len        = state == BIT ? W'(BIT_FRAMES) : W'(PULSE_FRAMES);
`ifdef SYNC_PARITY_EN
  assign word = {sec_tdata, ^sec_tdata};
`else
  assign word = sec_tdata;
`endif
  frame_timer #(.W(W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .tick (frame_tick),
    .len  (len),
    .done (done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      bit_idx  <= '0;
      sync_out <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sync_out <= state == START || (state == BIT && sh[NT-1]);
      if (sec_tvalid && !load && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (!en) state <= IDLE;
      else
        case (state)
          IDLE:  if (load) begin
                   state   <= START;
                   sh      <= word;
                   bit_idx <= '0;
                 end
          START: if (done) state <= GAP;
          GAP:   if (done) state <= BIT;
          BIT:   if (done) begin
                   sh      <= sh << 1;
                   bit_idx <= bit_idx + BW'(1);
                   if (bit_idx == BW'(NT - 1)) state <= IDLE;
                 end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_sync_barcode_sched.sv
// tb_sync_barcode_sched: randomized and directed checks against a tick-indexed barcode model.
module tb_sync_barcode_sched;
  localparam int PF = 2, BF = 4, NB = 12;
`ifdef SYNC_PARITY_EN
  localparam int NT = NB + 1;
`else
  localparam int NT = NB;
`endif
  localparam int TOTAL = 2 * PF + NT * BF;
  logic clk = 0, rst_n = 0, en = 0, frame_tick = 0, sec_tvalid = 0;
  logic [NB-1:0] sec_tdata = '0;
  logic sec_tready, sync_out, busy;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0, cyc = 0;
  logic m_busy = 0, m_sync = 0;
  int m_k = 0, m_drop = 0, seg_ticks = 0;
  logic [NB-1:0] m_word = '0;
  sync_barcode_sched #(.NBITS(NB), .PULSE_FRAMES(PF), .BIT_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_tick(frame_tick),
    .sec_tvalid(sec_tvalid), .sec_tdata(sec_tdata), .sec_tready(sec_tready),
    .sync_out(sync_out), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic wave(input int i, input logic [NB-1:0] w);
    int j;
    if (i < PF) return 1'b1;
    if (i < 2 * PF) return 1'b0;
    j = (i - 2 * PF) / BF;
    return j < NB ? w[NB-1-j] : ^w;
  endfunction
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic check_all();
    chk("busy", {7'd0, busy}, {7'd0, m_busy});
    chk("sync_out", {7'd0, sync_out}, {7'd0, m_sync});
    chk("drop_cnt", drop_cnt, 8'(m_drop));
    chk("tready", {7'd0, sec_tready}, 8'd1);
  endtask
  task automatic step(input logic e, input logic v, input logic [NB-1:0] d);
    logic acc;
    en = e; sec_tvalid = v; sec_tdata = d; frame_tick = (cyc % 3 == 0);
    @(posedge clk);
    m_sync = m_busy ? wave(m_k, m_word) : 1'b0;
    acc = v && e && !m_busy;
    if (v && !acc && m_drop < 255) m_drop++;
    if (!e) m_busy = 0;
    else if (acc) begin m_busy = 1; m_k = 0; m_word = d; end
    else if (m_busy && frame_tick) begin
      m_k++;
      if (m_k == TOTAL) m_busy = 0;
    end
    cyc++;
    #1 check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0);
  endtask
  task automatic drain(input string tag);
    int b = 0;
    while (m_busy && b < 400) begin step(1, 0, '0); b++; end
    chk({tag, "_bound"}, {7'd0, m_busy}, 8'd0);
    step(1, 0, '0);
  endtask
  task automatic align_tick(input bit on_tick);
    while ((cyc % 3 == 0) != on_tick) step(1, 0, '0);
  endtask
  initial begin
    #3 check_all();
    chk("rst_sync", {7'd0, sync_out}, 8'd0);
    @(posedge clk); #1 rst_n = 1;
    idle(4);
    // nominal word, loaded off a tick; count ticks until busy falls
    align_tick(0);
    step(1, 1, 12'hA5C);
    seg_ticks = 0;
    while (m_busy && seg_ticks < 200) begin
      if (cyc % 3 == 0) seg_ticks++;
      step(1, 0, '0);
    end
    chk("nominal_ticks", 8'(seg_ticks), 8'(TOTAL));
    drain("nominal");
    // back-to-back: second word 10 ticks later is dropped
    align_tick(0);
    step(1, 1, 12'h3C5);
    idle(30);
    step(1, 1, 12'h111);
    chk("b2b_drop", drop_cnt, 8'd1);
    drain("b2b");
    // tick coincident with load
    align_tick(1);
    step(1, 1, 12'hFFF);
    idle(4);
    chk("coinc_start_hold", {7'd0, sync_out}, 8'd1);
    drain("coinc");
    // en dropped during bit 5
    align_tick(0);
    step(1, 1, 12'h5A5);
    while (m_busy && m_k < 2 * PF + 5 * BF + 1 && cyc < 20000) step(1, 0, '0);
    step(0, 0, '0);
    chk("endrop_idle", {7'd0, busy}, 8'd0);
    step(1, 0, '0);
    chk("endrop_sync", {7'd0, sync_out}, 8'd0);
    step(1, 1, 12'h0F0);
    drain("after_endrop");
    // async reset during GAP
    step(1, 1, 12'h777);
    while (m_busy && m_k < PF + 1 && cyc < 20000) step(1, 0, '0);
    #2 rst_n = 0;
    #1;
    m_busy = 0; m_sync = 0; m_drop = 0;
    check_all();
    @(posedge clk); #1 rst_n = 1;
    idle(3);
    // saturation
    for (int i = 0; i < 300; i++) step(0, 1, 12'(i));
    chk("saturate", drop_cnt, 8'd255);
    // random words with random dropped attempts
    for (int n = 0; n < 6; n++) begin
      step(1, 1, 12'($urandom));
      for (int i = 0; i < 3 * TOTAL + 6; i++)
        step(1, ($urandom_range(0, 19) == 0), 12'($urandom));
      drain("random");
    end
    `ifdef SYNC_PARITY_EN
    step(1, 1, 12'h001);
    drain("parity");
    `endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
